// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default widths and address field helpers for the data caches
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_OFFSET_W = 2;
   localparam int DEF_INDEX_W  = 2;

   // Helpers work on a zero-extended 32-bit address; callers truncate to the field width.
   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w,
                                            input int offset_w);
      return addr >> (index_w + offset_w);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w,
                                              input int offset_w);
      return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
      return addr & ((32'd1 << offset_w) - 32'd1);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one cache way: valid/dirty/tag/data storage, tag compare and word access
module dcache_way
   import dcache_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W,
   localparam int BLOCK_W = DATA_W << OFFSET_W,
   localparam int SETS    = 1 << INDEX_W
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [INDEX_W-1:0]  index,
   input  logic [TAG_W-1:0]    tag,
   input  logic [OFFSET_W-1:0] offset,
   output logic                hit,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    stored_tag,
   output logic [BLOCK_W-1:0]  block,
   output logic [DATA_W-1:0]   word,
   input  logic                word_we,
   input  logic [DATA_W-1:0]   word_data,
   input  logic                block_we,
   input  logic [BLOCK_W-1:0]  block_data
);

   logic [SETS-1:0]    valid_q;
   logic [SETS-1:0]    dirty_q;
   logic [TAG_W-1:0]   tag_q  [SETS];
   logic [BLOCK_W-1:0] data_q [SETS];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (block_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tags and data are left uncleared by reset; valid alone qualifies them.
   always_ff @(posedge clock) begin
      if (block_we) begin
         tag_q[index]  <= tag;
         data_q[index] <= block_data;
      end else if (word_we) begin
         data_q[index][32'(offset)*DATA_W +: DATA_W] <= word_data;
      end
   end

   assign valid      = valid_q[index];
   assign dirty      = dirty_q[index];
   assign stored_tag = tag_q[index];
   assign block      = data_q[index];
   assign hit        = valid && (stored_tag == tag);
   assign word       = block[32'(offset)*DATA_W +: DATA_W];

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - two-way set-associative write-back, write-allocate data cache with LRU
module dcache_assoc
   import dcache_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int OFFSET_W = DEF_OFFSET_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
   localparam int BLOCK_W = DATA_W << OFFSET_W,
   localparam int MADDR_W = ADDR_W - OFFSET_W,
   localparam int SETS    = 1 << INDEX_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               read,
   input  logic               write,
   input  logic [ADDR_W-1:0]  address,
   input  logic [DATA_W-1:0]  writedata,
   output logic [DATA_W-1:0]  readdata,
   output logic               busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [MADDR_W-1:0] mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   state_t              state;
   logic                victim_q;
   logic [SETS-1:0]     lru_q;

   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  index;
   logic [OFFSET_W-1:0] offset;
   logic [MADDR_W-1:0]  block_addr;

   logic [1:0]          hit_w, valid_w, dirty_w, word_we_w, block_we_w;
   logic [TAG_W-1:0]    tag_w   [2];
   logic [BLOCK_W-1:0]  block_w [2];
   logic [DATA_W-1:0]   word_w  [2];

   logic                request, hit, hit_way, victim_sel;

   assign tag        = TAG_W'(addr_tag(32'(address), INDEX_W, OFFSET_W));
   assign index      = INDEX_W'(addr_index(32'(address), INDEX_W, OFFSET_W));
   assign offset     = OFFSET_W'(addr_offset(32'(address), OFFSET_W));
   assign block_addr = address[ADDR_W-1:OFFSET_W];

   for (genvar w = 0; w < 2; w++) begin : g_way
      assign word_we_w[w]  = (state == IDLE) && write && hit_w[w];
      assign block_we_w[w] = (state == UPDATE) && (victim_q == 1'(w));

      dcache_way #(
         .DATA_W   (DATA_W),
         .OFFSET_W (OFFSET_W),
         .INDEX_W  (INDEX_W),
         .TAG_W    (TAG_W)
      ) u_way (
         .clock      (clock),
         .reset_n    (reset_n),
         .index      (index),
         .tag        (tag),
         .offset     (offset),
         .hit        (hit_w[w]),
         .valid      (valid_w[w]),
         .dirty      (dirty_w[w]),
         .stored_tag (tag_w[w]),
         .block      (block_w[w]),
         .word       (word_w[w]),
         .word_we    (word_we_w[w]),
         .word_data  (writedata),
         .block_we   (block_we_w[w]),
         .block_data (mem_readdata)
      );
   end

   assign request  = read | write;
   assign hit      = |hit_w;
   assign hit_way  = hit_w[1];
   assign busywait = request & ~((state == IDLE) & hit);
   assign readdata = (read && hit) ? word_w[hit_way] : '0;

   // Fill empty ways first (way 0 before way 1), otherwise evict the least recently used.
   assign victim_sel = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[index]);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lru_q <= '0;
      end else if ((state == IDLE) && request && hit) begin
         lru_q[index] <= ~hit_way;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         victim_q      <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (request && !hit) begin
                  victim_q <= victim_sel;
                  if (valid_w[victim_sel] && dirty_w[victim_sel]) begin
                     state         <= WRITEBACK;
                     mem_write     <= 1'b1;
                     mem_address   <= {tag_w[victim_sel], index};
                     mem_writedata <= block_w[victim_sel];
                  end else begin
                     state       <= FETCH;
                     mem_read    <= 1'b1;
                     mem_address <= block_addr;
                  end
               end
            end
            WRITEBACK: begin
               if (!mem_busywait) begin
                  state         <= FETCH;
                  mem_write     <= 1'b0;
                  mem_writedata <= '0;
                  mem_read      <= 1'b1;
                  mem_address   <= block_addr;
               end
            end
            FETCH: begin
               if (!mem_busywait) begin
                  state       <= UPDATE;
                  mem_read    <= 1'b0;
                  mem_address <= '0;
               end
            end
            UPDATE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - self-checking bench: recency-list cache model, flat CPU memory view, memory responder
module tb_dcache_assoc;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        read = 1'b0, write = 1'b0;
   logic [7:0]  address = '0, writedata = '0;
   logic [7:0]  readdata;
   logic        busywait, mem_read, mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;
   logic        mem_busywait = 1'b0;

   dcache_assoc dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   always #5 clock = ~clock;

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // CPU-visible byte view, expected backing memory, and per-set recency lists (index 0 = least recent).
   logic [7:0]  cview [256];
   logic [31:0] bmem [64];
   logic [31:0] env_mem [64];
   int          n_ent [4];
   logic [3:0]  ent_tag [4][2];
   bit          ent_dirty [4][2];

   bit          req_active = 0, saw_fetch = 0, saw_wb = 0;
   bit          exp_miss, exp_wb;
   logic [5:0]  exp_wb_addr, exp_fetch_addr, last_wb_addr, last_fetch_addr;
   logic [31:0] exp_wb_data, last_wb_data;
   logic [7:0]  exp_rdata, last_rdata;
   int          mem_lat = 0, mem_cnt = 0, last_busy = 0;

   function automatic logic [31:0] view_block(input int blk);
      return {cview[4*blk+3], cview[4*blk+2], cview[4*blk+1], cview[4*blk]};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 4; s++) n_ent[s] = 0;
      for (int b = 0; b < 64; b++)
         for (int k = 0; k < 4; k++) cview[4*b+k] = bmem[b][8*k +: 8];
   endtask

   always @(negedge clock) begin
      if (mem_read | mem_write) begin
         if (mem_cnt < mem_lat) begin
            mem_busywait = 1'b1;
            mem_cnt++;
         end else begin
            mem_busywait = 1'b0;
            mem_cnt = 0;
            if (mem_write) env_mem[mem_address] = mem_writedata;
            else mem_readdata = env_mem[mem_address];
         end
      end else begin
         mem_busywait = 1'b0;
         mem_cnt = 0;
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         check("mem_excl", 64'(mem_read & mem_write), 0);
         if (!mem_write) check("wdata_quiet", mem_writedata, 0);
         if (mem_write) begin
            saw_wb = 1;
            last_wb_addr = mem_address;
            last_wb_data = mem_writedata;
            check("wb_addr", mem_address, exp_wb_addr);
            check("wb_data", mem_writedata, exp_wb_data);
         end else if (mem_read) begin
            saw_fetch = 1;
            last_fetch_addr = mem_address;
            check("fetch_addr", mem_address, exp_fetch_addr);
         end else begin
            check("addr_quiet", mem_address, 0);
         end
         if (!req_active) begin
            check("idle_busy", busywait, 0);
            check("idle_rdata", readdata, 0);
         end else if (read && !busywait) begin
            last_rdata = readdata;
            check("rdata", readdata, exp_rdata);
         end
      end
   end

   task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] wd);
      int s, pos, busy, exp_busy;
      bit done;
      logic [3:0] t;
      s = int'(a[3:2]);
      t = a[7:4];
      pos = -1;
      busy = 0;
      for (int i = 0; i < n_ent[s]; i++) if (ent_tag[s][i] == t) pos = i;
      exp_miss = (pos < 0);
      exp_wb = 0;
      if (exp_miss) begin
         if (n_ent[s] == 2) begin
            if (ent_dirty[s][0]) begin
               exp_wb = 1;
               exp_wb_addr = {ent_tag[s][0], a[3:2]};
               exp_wb_data = view_block(int'(exp_wb_addr));
               bmem[exp_wb_addr] = exp_wb_data;
            end
            ent_tag[s][0] = ent_tag[s][1];
            ent_dirty[s][0] = ent_dirty[s][1];
            n_ent[s] = 1;
         end
         ent_tag[s][n_ent[s]] = t;
         ent_dirty[s][n_ent[s]] = 0;
         n_ent[s]++;
         exp_fetch_addr = a[7:2];
      end else if (pos == 0 && n_ent[s] == 2) begin
         ent_tag[s][0] = ent_tag[s][1];
         ent_dirty[s][0] = ent_dirty[s][1];
         ent_tag[s][1] = t;
         ent_dirty[s][1] = ent_dirty[s][0] ^ ent_dirty[s][0] | ent_dirty_hit(s, pos);
      end
      if (wr) begin
         ent_dirty[s][n_ent[s]-1] = 1;
         cview[a] = wd;
      end
      exp_rdata = cview[a];
      exp_busy = exp_miss ? (2 + (mem_lat + 1) + (exp_wb ? mem_lat + 1 : 0)) : 0;

      @(posedge clock);
      #1;
      address = a;
      writedata = wd;
      read = !wr;
      write = wr;
      saw_fetch = 0;
      saw_wb = 0;
      req_active = 1;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clock);
         if (busywait) busy++;
         else done = 1;
      end
      check("req_done", 64'(done), 1);
      @(posedge clock);
      #1;
      read = 0;
      write = 0;
      req_active = 0;
      last_busy = busy;
      check("miss", 64'(saw_fetch), 64'(exp_miss));
      check("writeback", 64'(saw_wb), 64'(exp_wb));
      check("busy_cycles", busy, exp_busy);
   endtask

   // Dirtiness of the entry that was least recent before being promoted on a hit.
   bit lru_dirty_save;
   function automatic bit ent_dirty_hit(input int s, input int pos);
      return lru_dirty_save;
   endfunction

   task automatic promote_prep(input logic [7:0] a);
      int s;
      s = int'(a[3:2]);
      lru_dirty_save = (n_ent[s] > 0) ? ent_dirty[s][0] : 1'b0;
   endtask

   task automatic req(input bit wr, input logic [7:0] a, input logic [7:0] wd);
      promote_prep(a);
      do_req(wr, a, wd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 64; b++)
         bmem[b] = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)} ^ 32'hC3A5_5A3C;
      bmem[5] = 32'h44332211;
      for (int b = 0; b < 64; b++) env_mem[b] = bmem[b];
      model_reset();

      #1 reset_n = 1'b0;
      #2;
      check("rst_busywait", busywait, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_readdata", readdata, 0);
      check("rst_mem_address", mem_address, 0);
      @(negedge clock);
      #2 reset_n = 1'b1;

      req(0, 8'h14, 8'h00);
      check("t1_fetch_addr", last_fetch_addr, 6'h05);
      check("t1_readdata", last_rdata, 8'h11);
      check("t1_busy", last_busy, 3);

      req(1, 8'h15, 8'hAA);
      check("t2_write_no_mem", 64'(saw_fetch | saw_wb), 0);
      req(0, 8'h15, 8'h00);
      check("t2_readdata", last_rdata, 8'hAA);

      req(0, 8'h34, 8'h00);
      req(0, 8'h54, 8'h00);
      check("t3_wb_addr", last_wb_addr, 6'h05);
      check("t3_wb_data", last_wb_data, 32'h4433AA11);
      check("t3_fetch_addr", last_fetch_addr, 6'h15);
      check("t3_busy", last_busy, 4);

      req(0, 8'h14, 8'h00);
      req(0, 8'h34, 8'h00);
      req(0, 8'h14, 8'h00);
      req(0, 8'h54, 8'h00);
      req(0, 8'h14, 8'h00);
      check("t4_hit_no_fetch", 64'(saw_fetch), 0);
      req(0, 8'h34, 8'h00);
      check("t4_evicted_refetch", 64'(saw_fetch), 1);

      req(1, 8'h9B, 8'h5E);
      req(0, 8'h9B, 8'h00);
      check("wmiss_readback", last_rdata, 8'h5E);
      req(0, 8'h98, 8'h00);
      req(1, 8'h0C, 8'h77);
      req(1, 8'h4D, 8'h66);
      req(0, 8'h8E, 8'h00);
      req(0, 8'h0C, 8'h00);

      mem_lat = 5;
      req(0, 8'hC8, 8'h00);
      check("t5_busy", last_busy, 8);
      mem_lat = 0;

      mem_lat = 20;
      exp_fetch_addr = 6'h20;
      @(posedge clock);
      #1;
      address = 8'h80;
      read = 1;
      req_active = 1;
      @(negedge clock);
      @(negedge clock);
      #2;
      check("t6_pre_mem_read", mem_read, 1);
      reset_n = 1'b0;
      #1;
      check("t6_mem_read_async", mem_read, 0);
      check("t6_mem_address_async", mem_address, 0);
      check("t6_busy_in_reset", busywait, 1);
      read = 0;
      req_active = 0;
      model_reset();
      mem_lat = 0;
      @(posedge clock);
      #1;
      check("t6_busy_idle", busywait, 0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      req(0, 8'h14, 8'h00);
      check("t6_miss_again", 64'(saw_fetch), 1);
      check("t6_readdata", last_rdata, 8'h11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised two-way set-associative write-back, write-allocate data cache between the CPU load/store port and the block-wide data memory. Successor to the direct-mapped data cache: address, word and block widths and set count are parameters, and each set holds two ways with LRU replacement. The CPU stalls on `busywait`; misses are served by a writeback/fetch FSM on the same memory handshake as before.

## Interface

**Parameters**
- `ADDR_W`, 8: CPU byte-address width.
- `DATA_W`, 8: CPU word width.
- `OFFSET_W`, 2: log2 of words per block.
- `INDEX_W`, 2: log2 of set count.
- Derived: `TAG_W = ADDR_W-INDEX_W-OFFSET_W`, `BLOCK_W = DATA_W<<OFFSET_W`, `MADDR_W = ADDR_W-OFFSET_W`.

**Ports** (clock and reset first)
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `read` in 1: CPU load request.
- `write` in 1: CPU store request.
- `address` in ADDR_W: split as {tag, index, offset}.
- `writedata` in DATA_W: store data.
- `readdata` out DATA_W: load data.
- `busywait` out 1: CPU stall.
- `mem_read` out 1: memory block read.
- `mem_write` out 1: memory block write.
- `mem_address` out MADDR_W: memory block address.
- `mem_writedata` out BLOCK_W: writeback block.
- `mem_readdata` in BLOCK_W: fetched block.
- `mem_busywait` in 1: memory busy.

## Operation

- **Per-set state**
  - Per way: `valid`, `dirty`, `tag`, and a BLOCK_W data block.
  - Per set: one `lru` bit, which names the way to evict next.
- **Lookup** (combinational)
  - A way hits if `valid` is set and its tag equals `address` tag.
  - Two-way hit is impossible by construction.
- **CPU handshake**
  - CPU holds `read`/`write`/`address`/`writedata` stable until it samples `busywait`=0 at a rising edge.
  - `read` and `write` are never both high.
  - `busywait = (read|write) & !(state==IDLE & hit)`.
- **Read hit**
  - `readdata` = word `offset` of the hit block, combinational.
  - `lru` ← other way at the edge.
- **Write hit**
  - At the edge: word `offset` of the hit block ← `writedata`, `dirty` ← 1, `lru` ← other way.
- **Victim selection on a miss**
  - First invalid way, way 0 preferred.
  - Otherwise the way named by `lru`.
  - The victim is latched on leaving IDLE.
- **FSM states:** IDLE, WRITEBACK, FETCH, UPDATE.
  - IDLE → WRITEBACK: miss and victim valid and dirty.
  - IDLE → FETCH: miss and victim not dirty.
  - WRITEBACK: `mem_write`=1, `mem_address`={victim tag, index}, `mem_writedata`=victim block. Stays while `mem_busywait`, then → FETCH.
  - FETCH: `mem_read`=1, `mem_address`=`address[ADDR_W-1:OFFSET_W]`. Stays while `mem_busywait`, then → UPDATE.
  - UPDATE: at the edge, victim block ← `mem_readdata`, tag written, `valid`=1, `dirty`=0. → IDLE.
  - Back in IDLE the request hits and completes as a normal hit, so the write-allocate store is applied there.
- **Memory outputs**
  - Registered from state.
  - Outside WRITEBACK/FETCH: `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0.
- **Reset** (asynchronous, any cycle, including mid-miss)
  - State → IDLE.
  - All `valid`, `dirty` and `lru` ← 0.
  - Memory strobes drop immediately.
  - Data and tag arrays are not cleared.
  - `readdata` is 0 when there is no read hit.
- **Idle cycles:** no request leaves all state untouched, and `busywait`=0.

## Timing

- **Hit latency:** `busywait` stays low and the request completes at the first edge.
- **Clean miss:** 1 (IDLE) + FETCH cycles (≥1) + 1 (UPDATE) + 1 (hit).
  - With a 1-cycle memory: `busywait` is high for 3 edges, and the request completes at the 4th.
- **Dirty miss:** clean-miss latency plus WRITEBACK cycles (≥1).
- **Memory handshake:**
  - `mem_read`/`mem_write` are held until the edge where `mem_busywait`=0 is sampled.
  - They are never both high.
  - `mem_readdata` is captured in UPDATE, one edge after that.
- **Request change:** a request that changes while `busywait`=1 is a protocol violation and its behaviour is undefined.

## Structure

- Shared package `dcache_pkg`:
  - FSM state enum (`IDLE`, `WRITEBACK`, `FETCH`, `UPDATE`).
  - Default width localparams.
  - Tag/index/offset field-extract functions.
- Sub-module `dcache_way`:
  - One way's valid/dirty/tag/data storage.
  - Tag compare, hit output, word read mux, and word/block write ports.
  - Instantiated twice in `dcache_assoc`.
- The LRU bits and the FSM stay in the top level.

## Test plan

All addresses below use the default parameters.

1. **Reset, then read 0x14.**
   - `busywait`=1 and `mem_read`=1 with `mem_address`=0x05.
   - Memory returns 0x44332211 → `readdata`=0x11, and `busywait` drops after UPDATE.
2. **Write hit: write 0xAA to 0x15, then read 0x15.**
   - Both complete with no memory access, and `readdata`=0xAA.
3. **Conflict fill: after test 2, read 0x34 and then 0x54** (all in set 1).
   - 0x34 fills way 1.
   - 0x54 evicts the tag-1 block: WRITEBACK with `mem_address`=0x05 and `mem_writedata`=0x4433AA11, then FETCH of 0x15.
4. **LRU update: read 0x14, 0x34, 0x14, then 0x54.**
   - The 0x34 block is evicted.
   - A following read of 0x14 hits with no memory activity.
5. **Memory stall:** `mem_busywait` held high for 5 cycles during FETCH.
   - `mem_read` and `mem_address` stay stable, and `busywait` stays high throughout.
6. **Reset mid-miss:** `reset_n` pulled low during FETCH.
   - `mem_read` falls without waiting for a clock edge.
   - After release, a read of 0x14 misses again.
